// File: rtl/adc_burst_capture.sv
// adc_burst_capture: programmable-rate ADC sample clock generator with
// pipeline-latency compensation and burst/continuous capture.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   en                block enable; low aborts any activity
//   start             one-cycle start request (IDLE only)
//   div               sclk half-period minus one, in clk cycles (latched at start)
//   burst_len         samples to emit, 0 = continuous (latched at start)
//   adc_data          ADC output bus
//   sclk              registered ADC sample clock
//   dout, dout_valid  captured sample and its one-cycle strobe
//   busy              high while running
//   done              one-cycle pulse when a burst completes
//
// Build option: define ADC_OFFSET_BIN_EN to convert captured offset-binary
// data to two's complement (MSB inverted) before it reaches dout.

module adc_burst_capture #(
  parameter int unsigned CNT_W    = 12,
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned LEN_W    = 16,
  parameter int unsigned PIPE_LAT = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              start,
  input  logic [CNT_W-1:0]  div,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic [DATA_W-1:0] adc_data,
  output logic              sclk,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              busy,
  output logic              done
);

  // Fall counter only needs to reach PIPE_LAT, then it saturates.
  localparam int unsigned F_W = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);
  localparam logic [F_W-1:0] F_MAX = F_W'(PIPE_LAT);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t state, state_d;

  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [CNT_W-1:0]  div_q, div_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  n, n_d;
  logic [F_W-1:0]    f, f_d;
  logic              fin_q, fin_d;
  logic              sclk_d;
  logic [DATA_W-1:0] dout_d;
  logic              dout_valid_d;
  logic              busy_d;
  logic              done_d;

  logic              tick;
  logic              fall;
  logic              emit;
  logic              last;
  logic [DATA_W-1:0] cap;

  // Divider terminal count, sclk falling edge, and whether this fall emits.
  assign tick = (cnt == div_q);
  assign fall = tick & sclk;
  assign emit = fall & (f == F_MAX);
  assign last = emit & (len_q != '0) & ((n + 1'b1) == len_q);

`ifdef ADC_OFFSET_BIN_EN
  assign cap = {~adc_data[DATA_W-1], adc_data[DATA_W-2:0]};
`else
  assign cap = adc_data;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic; fin_q delays the return to IDLE by one cycle after the last sample.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (en && start) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!en || fin_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the datapath and registered outputs.
  always_comb begin
    cnt_d        = cnt;
    div_d        = div_q;
    len_d        = len_q;
    n_d          = n;
    f_d          = f;
    fin_d        = 1'b0;
    sclk_d       = sclk;
    dout_d       = dout;
    dout_valid_d = 1'b0;
    done_d       = 1'b0;
    busy_d       = (state_d == S_RUN);
    case (state)
      S_IDLE: begin
        cnt_d  = '0;
        sclk_d = 1'b0;
        n_d    = '0;
        f_d    = '0;
        if (en && start) begin
          div_d = div;
          len_d = burst_len;
        end
      end
      S_RUN: begin
        if (!en || fin_q) begin
          // Abort or burst completion: park with sclk low.
          cnt_d  = '0;
          sclk_d = 1'b0;
          n_d    = '0;
          f_d    = '0;
          done_d = en & fin_q;
        end else begin
          cnt_d = tick ? '0 : cnt + 1'b1;
          if (tick) begin
            sclk_d = ~sclk;
          end
          if (fall) begin
            if (emit) begin
              dout_d       = cap;
              dout_valid_d = 1'b1;
              n_d          = n + 1'b1;
              fin_d        = last;
            end else begin
              f_d = f + 1'b1;
            end
          end
        end
      end
      default: begin
        cnt_d  = '0;
        sclk_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      div_q      <= '0;
      len_q      <= '0;
      n          <= '0;
      f          <= '0;
      fin_q      <= 1'b0;
      sclk       <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      cnt        <= cnt_d;
      div_q      <= div_d;
      len_q      <= len_d;
      n          <= n_d;
      f          <= f_d;
      fin_q      <= fin_d;
      sclk       <= sclk_d;
      dout       <= dout_d;
      dout_valid <= dout_valid_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

endmodule

// File: doc/adc_burst_capture.md
# adc_burst_capture

Parametrised successor to the fixed ADC clock divider. Generates a programmable-rate sample clock for a pipelined ADC (AD9235 class), compensates for the converter's pipeline latency, and captures a configurable burst of samples (or a continuous stream) into a registered output with a valid strobe. Sits between the ADC pins and the sample FIFO/DMA front end; all control is register-driven from the AXI-lite wrapper.

## Interface
- `CNT_W`, 12: width of the divider count `div`.
- `DATA_W`, 12: ADC data width.
- `LEN_W`, 16: width of the burst length and sample counter.
- `PIPE_LAT`, 7: ADC pipeline latency in sample-clock periods; this many leading captures are discarded.

- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: block enable; low aborts any activity.
- `start` in 1: one-cycle start request, honoured only in IDLE with `en`=1.
- `div` in CNT_W: half-period minus one, in `clk` cycles; latched at start.
- `burst_len` in LEN_W: samples to emit; 0 = continuous; latched at start.
- `adc_data` in DATA_W: ADC output bus.
- `sclk` out 1: ADC sample clock, registered.
- `dout` out DATA_W: captured sample, registered.
- `dout_valid` out 1: one-cycle strobe, `dout` is valid.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse on burst completion.

## Operation
- States: IDLE, RUN. Reset and abort force IDLE.
- IDLE: `sclk`=0, counters 0, `busy`=0. `start`&`en` → latch `div`, `burst_len` into `div_q`, `len_q`; go RUN.
- RUN: divider `cnt` counts 0..`div_q`; when `cnt`==`div_q`, `cnt`←0 and `sclk`←~`sclk`. Period = 2·(`div_q`+1) clk; `div_q`=0 gives clk/2, 50% duty always.
- Capture on falling edge: in the cycle `sclk` toggles 1→0, `adc_data` is registered. Fall counter `f` (saturating at `PIPE_LAT`) discards the first `PIPE_LAT` captures; subsequent captures load `dout` and pulse `dout_valid`.
- Sample counter `n` increments per emitted sample. When `len_q`≠0 and the emitted sample is number `len_q`: return to IDLE next cycle, `sclk` held low, `done` pulses.
- `len_q`=0: run until `en` drops; `n` wraps modulo 2^LEN_W without effect; no `done`.
- `en` low in any state: next cycle IDLE, `sclk`=0, `dout_valid`=0, `done`=0, `dout` retains last value; aborted bursts produce no `done`.
- `start` while RUN is ignored; `div`/`burst_len` changes in RUN have no effect until next start.

## Timing
- Reset values: `sclk`=0, `dout`=0, `dout_valid`=0, `busy`=0, `done`=0.
- `start` sampled at edge t → `busy`=1 from t+1; first `sclk` rise visible at t+1+(`div_q`+1).
- `dout`/`dout_valid` update on the same edge that drives `sclk` low; latency from that edge: 0 cycles.
- First `dout_valid` on the (`PIPE_LAT`+1)th falling edge, i.e. (2·`PIPE_LAT`+2)·(`div_q`+1) clk after RUN entry.
- Last sample: `dout_valid` at edge e, `done`=1 and `busy`=0 at e+1; `sclk` remains low (no extra rise).
- `start` on the cycle `done` is high is honoured (state already IDLE).

## Configuration
- `ADC_OFFSET_BIN_EN`: defined → captured data is converted from offset binary to two's complement (MSB inverted) before loading `dout`. Undefined → `dout` is the raw `adc_data` bit pattern. No timing difference either way.

## Test plan
- Reset mid-burst: assert `rst_n`=0 asynchronously during RUN → all outputs 0 immediately, no `done` after release.
- `div`=0, `burst_len`=4, ramp on `adc_data` → `sclk` period 2 clk, 7 falls discarded, exactly 4 `dout_valid` at falls 8–11, `done` one cycle after 4th, `busy` 0.
- `div`=3, `burst_len`=1 → `sclk` high 4 / low 4 clk; single `dout_valid` 64 clk after RUN entry; `done` next cycle.
- `burst_len`=0, `div`=1, run 100 samples then `en`=0 → continuous valids every 4 clk, abort to IDLE next cycle, `sclk`=0, no `done`.
- `start` during RUN and `div` change mid-burst → ignored; period unchanged; back-to-back `start` on `done` cycle starts new burst.
- With `ADC_OFFSET_BIN_EN`: `adc_data`=12'h800 → `dout`=12'h000; 12'h000 → 12'h800; without macro, passed unchanged.
